// File: rtl/tm1637_display_ctrl_if.sv
// Request/status and pad-side signals of the TM1637 display controller.
//   digits_i       segment bitmasks, byte k = tile k
//   brightness_i   PWM level 0..7
//   disp_on_i      display enable bit
//   disp_strobe_i  refresh request, taken only while idle
//   busy_o         refresh in progress
//   done_o         one-cycle pulse at the end of every refresh
//   ack_error_o    sticky: last refresh failed
//   sda_out        SDA level when driven
//   sda_in         SDA pad sample
//   sda_out_en     SDA drive enable (0 = released)
//   seg_scl_o      SCL
// slave is the controller side, master is the encoder/pad side.
interface tm1637_display_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [8*NUM_DIGITS-1:0] digits_i;
  logic [2:0]              brightness_i;
  logic                    disp_on_i;
  logic                    disp_strobe_i;
  logic                    busy_o;
  logic                    done_o;
  logic                    ack_error_o;
  logic                    sda_out;
  logic                    sda_in;
  logic                    sda_out_en;
  logic                    seg_scl_o;

  modport slave (
    input  digits_i, brightness_i, disp_on_i, disp_strobe_i, sda_in,
    output busy_o, done_o, ack_error_o, sda_out, sda_out_en, seg_scl_o
  );

  modport master (
    output digits_i, brightness_i, disp_on_i, disp_strobe_i, sda_in,
    input  busy_o, done_o, ack_error_o, sda_out, sda_out_en, seg_scl_o
  );
endinterface

// File: rtl/tm1637_display_ctrl.sv
// TM1637-style 2-wire display controller with its own serial bit engine.
// Each refresh sends three frames: data command (0x40), start address 0xC0
// followed by NUM_DIGITS tile bytes, and the display-control byte carrying
// brightness and on/off. Inputs are snapshotted when a strobe is accepted.
// A NACKed frame is stopped and resent up to MAX_RETRIES extra times; when
// the retries run out the refresh ends with ack_error_o set.
// Ports:
//   clk_i          system clock
//   porb_i         asynchronous active-low reset
//   sync_reset_i   synchronous abort to idle (bus released, no stop)
//   bus            request/status and pad signals (slave modport)
module tm1637_display_ctrl #(
  parameter int CLK_DIV     = 1,
  parameter int NUM_DIGITS  = 4,
  parameter int MAX_RETRIES = 2
) (
  input  logic                  clk_i,
  input  logic                  porb_i,
  input  logic                  sync_reset_i,
  tm1637_display_ctrl_if.slave  bus
);

  localparam int               DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO    = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
  localparam logic [2:0]       RETRY_INIT  = 3'(MAX_RETRIES);
  localparam logic [2:0]       F1_LAST_IDX = 3'(NUM_DIGITS);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_BIT_LO, S_BIT_HI, S_ACK_LO, S_ACK_HI,
    S_STOP_A, S_STOP_B, S_STOP_C, S_GAP
  } state_t;

  state_t                  state_r;
  logic [DIV_W-1:0]        div_cnt_r;
  logic [8*NUM_DIGITS-1:0] digits_r;
  logic [2:0]              bright_r;
  logic                    on_r;
  logic [1:0]              frame_r;
  logic [2:0]              byte_idx_r;
  logic [2:0]              bit_idx_r;
  logic [7:0]              shift_r;
  logic [2:0]              retry_r;
  logic                    nack_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    ack_err_r;
  logic                    sda_r;
  logic                    sda_en_r;
  logic                    scl_r;

  logic                    tick_s;
  logic                    last_byte_s;
  logic [7:0]              first_byte_s;
  logic [7:0]              next_byte_s;

  // Byte idx of frame `frame`; frame 1 byte 0 is the address, tiles follow.
  function automatic logic [7:0] byte_sel(input logic [1:0]              frame,
                                          input logic [2:0]              idx,
                                          input logic [8*NUM_DIGITS-1:0] dig,
                                          input logic                    on,
                                          input logic [2:0]              br);
    logic [7:0] b;
    b = 8'h40;
    case (frame)
      2'd0: b = 8'h40;
      2'd1: begin
        b = 8'hC0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
          b = (idx == 3'(k + 1)) ? dig[8*k +: 8] : b;
        end
      end
      2'd2:    b = {4'h8, on, br};
      default: b = 8'h40;
    endcase
    return b;
  endfunction

  // Tick strobe and byte selection for the current frame position.
  always_comb begin
    tick_s       = (div_cnt_r == DIV_LAST);
    first_byte_s = byte_sel(frame_r, 3'd0, digits_r, on_r, bright_r);
    next_byte_s  = byte_sel(frame_r, byte_idx_r + 3'd1, digits_r, on_r, bright_r);
    if (frame_r == 2'd1) begin
      last_byte_s = (byte_idx_r == F1_LAST_IDX);
    end else begin
      last_byte_s = 1'b1;
    end
  end

  // Refresh sequencer: tick divider, frame/byte/bit stepping, retries, pins.
  always_ff @(posedge clk_i or negedge porb_i) begin
    if (!porb_i) begin
      state_r    <= S_IDLE;
      div_cnt_r  <= DIV_ZERO;
      digits_r   <= {(8*NUM_DIGITS){1'b0}};
      bright_r   <= 3'd0;
      on_r       <= 1'b0;
      frame_r    <= 2'd0;
      byte_idx_r <= 3'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      retry_r    <= 3'd0;
      nack_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ack_err_r  <= 1'b0;
      sda_r      <= 1'b1;
      sda_en_r   <= 1'b0;
      scl_r      <= 1'b1;
    end else if (sync_reset_i) begin
      // Abort: release the bus at once, no stop condition, no done pulse.
      state_r    <= S_IDLE;
      div_cnt_r  <= DIV_ZERO;
      nack_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ack_err_r  <= 1'b0;
      sda_r      <= 1'b1;
      sda_en_r   <= 1'b0;
      scl_r      <= 1'b1;
    end else begin
      done_r <= 1'b0;
      if (state_r == S_IDLE) begin
        div_cnt_r <= DIV_ZERO;
        if (bus.disp_strobe_i) begin
          digits_r   <= bus.digits_i;
          bright_r   <= bus.brightness_i;
          on_r       <= bus.disp_on_i;
          frame_r    <= 2'd0;
          byte_idx_r <= 3'd0;
          retry_r    <= RETRY_INIT;
          nack_r     <= 1'b0;
          busy_r     <= 1'b1;
          ack_err_r  <= 1'b0;
          state_r    <= S_START;
          scl_r      <= 1'b1;
          sda_r      <= 1'b0;
          sda_en_r   <= 1'b1;
        end
      end else begin
        div_cnt_r <= tick_s ? DIV_ZERO : div_cnt_r + DIV_ONE;
        if (tick_s) begin
          case (state_r)
            S_START: begin
              shift_r   <= first_byte_s;
              bit_idx_r <= 3'd0;
              state_r   <= S_BIT_LO;
              scl_r     <= 1'b0;
              sda_r     <= first_byte_s[0];
            end
            S_BIT_LO: begin
              state_r <= S_BIT_HI;
              scl_r   <= 1'b1;
            end
            S_BIT_HI: begin
              scl_r <= 1'b0;
              if (bit_idx_r == 3'd7) begin
                state_r  <= S_ACK_LO;
                sda_r    <= 1'b1;
                sda_en_r <= 1'b0;
              end else begin
                state_r   <= S_BIT_LO;
                bit_idx_r <= bit_idx_r + 3'd1;
                shift_r   <= {1'b0, shift_r[7:1]};
                sda_r     <= shift_r[1];
              end
            end
            S_ACK_LO: begin
              state_r <= S_ACK_HI;
              scl_r   <= 1'b1;
            end
            S_ACK_HI: begin
              scl_r <= 1'b0;
              // NACK abandons the rest of the frame and goes straight to stop.
              if (bus.sda_in || last_byte_s) begin
                nack_r   <= bus.sda_in;
                state_r  <= S_STOP_A;
                sda_r    <= 1'b0;
                sda_en_r <= 1'b1;
              end else begin
                byte_idx_r <= byte_idx_r + 3'd1;
                shift_r    <= next_byte_s;
                bit_idx_r  <= 3'd0;
                state_r    <= S_BIT_LO;
                sda_r      <= next_byte_s[0];
                sda_en_r   <= 1'b1;
              end
            end
            S_STOP_A: begin
              state_r <= S_STOP_B;
              scl_r   <= 1'b1;
            end
            S_STOP_B: begin
              state_r  <= S_STOP_C;
              sda_r    <= 1'b1;
              sda_en_r <= 1'b0;
            end
            S_STOP_C: begin
              state_r <= S_GAP;
            end
            S_GAP: begin
              byte_idx_r <= 3'd0;
              if (nack_r && (retry_r != 3'd0)) begin
                retry_r  <= retry_r - 3'd1;
                nack_r   <= 1'b0;
                state_r  <= S_START;
                sda_r    <= 1'b0;
                sda_en_r <= 1'b1;
              end else if (nack_r || (frame_r == 2'd2)) begin
                ack_err_r <= nack_r;
                nack_r    <= 1'b0;
                busy_r    <= 1'b0;
                done_r    <= 1'b1;
                state_r   <= S_IDLE;
              end else begin
                frame_r  <= frame_r + 2'd1;
                retry_r  <= RETRY_INIT;
                state_r  <= S_START;
                sda_r    <= 1'b0;
                sda_en_r <= 1'b1;
              end
            end
            default: begin
              state_r  <= S_IDLE;
              busy_r   <= 1'b0;
              scl_r    <= 1'b1;
              sda_r    <= 1'b1;
              sda_en_r <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.busy_o      = busy_r;
  assign bus.done_o      = done_r;
  assign bus.ack_error_o = ack_err_r;
  assign bus.sda_out     = sda_r;
  assign bus.sda_out_en  = sda_en_r;
  assign bus.seg_scl_o   = scl_r;

endmodule
